// File: rtl/btn_sync_bank.sv
// btn_sync_bank: bank of N independent button conditioners.
// Each channel has a 2-flop synchroniser, a debouncer, rise/fall pulses,
// a toggle state and a long-press pulse.
// Ports:
//   clk, rst (async, active-high)
//   btn[N]        raw asynchronous button inputs
//   clr_toggle[N] synchronous clear of toggle state (wins over rise)
//   level[N]      debounced level
//   rise[N]       one-cycle pulse on debounced 0->1
//   fall[N]       one-cycle pulse on debounced 1->0
//   toggle[N]     flips on each rise
//   long_press[N] one-cycle pulse after LONG_CYCLES cycles held high
//   any_rise      OR of rise, registered alongside it
module btn_sync_bank #(
    parameter int N           = 5,
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    input  logic [N-1:0] clr_toggle,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] toggle,
    output logic [N-1:0] long_press,
    output logic         any_rise
);

    localparam int DBW_RAW = $clog2(DB_CYCLES + 1);
    localparam int HW_RAW  = $clog2(LONG_CYCLES + 1);
    localparam int DBW     = (DBW_RAW < 1) ? 1 : DBW_RAW;
    localparam int HW      = (HW_RAW < 1) ? 1 : HW_RAW;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [N-1:0]          s1_q, s1_d;
    logic [N-1:0]          s2_q, s2_d;
    logic [N-1:0]          level_q, level_d;
    logic [N-1:0]          rise_q, rise_d;
    logic [N-1:0]          fall_q, fall_d;
    logic [N-1:0]          toggle_q, toggle_d;
    logic [N-1:0]          long_q, long_d;
    logic                  any_rise_q, any_rise_d;
    logic [N-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [N-1:0][HW-1:0]  hold_q, hold_d;

    always_comb begin
        s1_d       = btn;
        s2_d       = s1_q;
        level_d    = level_q;
        rise_d     = '0;
        fall_d     = '0;
        toggle_d   = toggle_q;
        long_d     = '0;
        db_cnt_d   = '0;
        hold_d     = '0;
        any_rise_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Count consecutive disagreeing samples; any agreement restarts.
            if (s2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            if (rise_d[i]) begin
                toggle_d[i] = ~toggle_q[i];
            end
            if (clr_toggle[i]) begin
                toggle_d[i] = 1'b0;
            end
            // Hold counter saturates, so the LAST match happens once per press.
            if (level_q[i]) begin
                if (hold_q[i] != HOLD_MAX) begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end else begin
                    hold_d[i] = hold_q[i];
                end
                long_d[i] = (hold_q[i] == HOLD_LAST);
            end
        end
        any_rise_d = |rise_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            toggle_q   <= '0;
            long_q     <= '0;
            any_rise_q <= 1'b0;
            db_cnt_q   <= '0;
            hold_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            toggle_q   <= toggle_d;
            long_q     <= long_d;
            any_rise_q <= any_rise_d;
            db_cnt_q   <= db_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign toggle     = toggle_q;
    assign long_press = long_q;
    assign any_rise   = any_rise_q;

endmodule

// File: tb/tb_btn_sync_bank.sv
// tb_btn_sync_bank: directed scenarios plus random stimulus for
// btn_sync_bank, checked against a sample-window reference model.
module tb_btn_sync_bank;

    localparam int N    = 5;
    localparam int DB   = 4;
    localparam int LONG = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clr_toggle = '0;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] toggle;
    logic [N-1:0] long_press;
    logic         any_rise;

    btn_sync_bank #(
        .N(N),
        .DB_CYCLES(DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .clr_toggle(clr_toggle),
        .level(level),
        .rise(rise),
        .fall(fall),
        .toggle(toggle),
        .long_press(long_press),
        .any_rise(any_rise)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, obs, exp, $time);
        end
    endtask

    // Reference model: level flips when the last DB synchronised samples
    // all disagree with it; long press fires LONG edges after the rise.
    logic [N-1:0] samp[$];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    logic [N-1:0] m_tog = '0;
    logic [N-1:0] m_long = '0;
    logic         m_any = 1'b0;
    int           rise_e[N];
    int           t = 0;

    int n_rise[N];
    int n_fall[N];
    int n_long[N];
    int n_any;
    int o_rise_e[N];
    int o_fall_e[N];
    int o_long_e[N];

    task automatic model_step(input logic [N-1:0] b, input logic [N-1:0] c,
                              input logic r);
        bit flip;
        int idx;
        if (r) begin
            samp.push_back('0);
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_tog   = '0;
            m_long  = '0;
            m_any   = 1'b0;
        end else begin
            samp.push_back(b);
            m_rise = '0;
            m_fall = '0;
            m_long = '0;
            for (int i = 0; i < N; i++) begin
                if (m_level[i] && (t - rise_e[i] == LONG))
                    m_long[i] = 1'b1;
                flip = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    idx = t - 2 - k;
                    if (idx < 0) flip = 1'b0;
                    else if (samp[idx][i] == m_level[i]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_rise[i] = 1'b1;
                        rise_e[i] = t;
                    end else begin
                        m_fall[i] = 1'b1;
                    end
                end
                if (c[i]) m_tog[i] = 1'b0;
                else if (m_rise[i]) m_tog[i] = ~m_tog[i];
            end
            m_any = |m_rise;
        end
        t++;
    endtask

    task automatic clr_obs();
        for (int i = 0; i < N; i++) begin
            n_rise[i] = 0;
            n_fall[i] = 0;
            n_long[i] = 0;
            o_rise_e[i] = -1000;
            o_fall_e[i] = -1000;
            o_long_e[i] = -1000;
        end
        n_any = 0;
    endtask

    // One cycle: check state at the falling edge, then drive new inputs.
    task automatic cyc(input logic [N-1:0] b, input logic [N-1:0] c,
                       input logic r);
        @(negedge clk);
        chk("level", 32'(level), 32'(m_level));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("toggle", 32'(toggle), 32'(m_tog));
        chk("long_press", 32'(long_press), 32'(m_long));
        chk("any_rise", 32'(any_rise), 32'(m_any));
        for (int i = 0; i < N; i++) begin
            if (rise[i] === 1'b1) begin
                n_rise[i]++;
                o_rise_e[i] = t - 1;
            end
            if (fall[i] === 1'b1) begin
                n_fall[i]++;
                o_fall_e[i] = t - 1;
            end
            if (long_press[i] === 1'b1) begin
                n_long[i]++;
                o_long_e[i] = t - 1;
            end
        end
        if (any_rise === 1'b1) n_any++;
        btn = b;
        clr_toggle = c;
        rst = r;
        if (r) begin
            #1;
            chk("rst_async",
                32'({level, rise, fall, toggle, long_press, any_rise}), 32'd0);
        end
        model_step(b, c, r);
    endtask

    task automatic run(input logic [N-1:0] b, input logic [N-1:0] c,
                       input int n);
        for (int j = 0; j < n; j++) cyc(b, c, 1'b0);
    endtask

    int           e0;
    int           rem[N];
    logic [N-1:0] rb;
    logic [N-1:0] rc;

    initial begin
        for (int i = 0; i < N; i++) rise_e[i] = -1000;
        clr_obs();
        for (int j = 0; j < 3; j++) cyc('0, '0, 1'b1);
        run('0, '0, 4);

        // Clean step on channel 0.
        clr_obs();
        e0 = t;
        run(5'b00001, '0, 12);
        chk("step_lat", 32'(o_rise_e[0] - e0 + 1), 32'd6);
        chk("step_rise_n", 32'(n_rise[0]), 32'd1);
        chk("step_any_n", 32'(n_any), 32'd1);
        chk("step_tog", 32'(toggle[0]), 32'd1);
        run('0, '0, 10);

        // Three-cycle glitch on channel 1.
        clr_obs();
        run(5'b00010, '0, 3);
        run('0, '0, 12);
        chk("glitch_rise", 32'(n_rise[1] + n_any), 32'd0);
        chk("glitch_fall", 32'(n_fall[1]), 32'd0);
        chk("glitch_lvl", 32'(level), 32'd0);

        // Long press on channel 2.
        clr_obs();
        run(5'b00100, '0, 40);
        chk("long_n", 32'(n_long[2]), 32'd1);
        chk("long_lat", 32'(o_long_e[2] - o_rise_e[2]), 32'd16);
        e0 = t;
        run('0, '0, 10);
        chk("long_fall_lat", 32'(o_fall_e[2] - e0 + 1), 32'd6);

        // Short press on channel 2.
        clr_obs();
        run(5'b00100, '0, 10);
        run('0, '0, 12);
        chk("short_rise", 32'(n_rise[2]), 32'd1);
        chk("short_fall", 32'(n_fall[2]), 32'd1);
        chk("short_long", 32'(n_long[2]), 32'd0);

        // Toggle clear coinciding with rise on channel 3.
        clr_obs();
        run(5'b01000, '0, 5);
        cyc(5'b01000, 5'b01000, 1'b0);
        run(5'b01000, '0, 4);
        chk("tclr_rise", 32'(n_rise[3]), 32'd1);
        chk("tclr_tog", 32'(toggle[3]), 32'd0);
        run('0, '0, 10);
        run(5'b01000, '0, 10);
        chk("tclr_tog2", 32'(toggle[3]), 32'd1);
        run('0, '0, 10);

        // Reset while channel 4 hold count is 8.
        run(5'b10000, '0, 14);
        for (int j = 0; j < 3; j++) cyc(5'b10000, '0, 1'b1);
        clr_obs();
        e0 = t;
        run(5'b10000, '0, 30);
        chk("rst_rise_lat", 32'(o_rise_e[4] - e0 + 1), 32'd6);
        chk("rst_long_lat", 32'(o_long_e[4] - o_rise_e[4]), 32'd16);
        chk("rst_long_n", 32'(n_long[4]), 32'd1);
        run('0, '0, 10);

        // Random stimulus: per-channel runs of random length.
        for (int i = 0; i < N; i++) rem[i] = 0;
        rb = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    rb[i] = ~rb[i];
                    rem[i] = int'($urandom_range(1, 40));
                end
                rem[i]--;
                rc[i] = ($urandom_range(0, 7) == 0);
            end
            cyc(rb, rc, (c >= 700 && c < 703));
        end
        run('0, '0, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_sync_bank.md
BTN_SYNC_BANK -- requirements
Module: btn_sync_bank

Parameters
REQ-001 The block SHALL have parameter N, default 5, giving the number of independent button channels (N >= 1).
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, giving the consecutive synchronised samples needed to accept a level change (DB_CYCLES >= 1).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 16, giving the debounced-high cycles that define a long press (LONG_CYCLES >= 1).

Interface
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 btn  in  N  raw asynchronous button inputs, one bit per channel.
REQ-007 clr_toggle  in  N  synchronous per-channel clear of the toggle state.
REQ-008 level  out  N  debounced level per channel.
REQ-009 rise  out  N  one-cycle pulse on each debounced 0->1 transition.
REQ-010 fall  out  N  one-cycle pulse on each debounced 1->0 transition.
REQ-011 toggle  out  N  per-channel state that flips on each rise.
REQ-012 long_press  out  N  one-cycle pulse when a channel has been held for LONG_CYCLES.
REQ-013 any_rise  out  1  OR of rise.

Function
REQ-014 Each channel SHALL pass btn through a two-flop synchroniser (s1, s2); no other logic SHALL sample btn directly.
REQ-015 Each channel SHALL have a debounce counter that is cleared in any cycle where s2 equals level.
REQ-016 When s2 differs from level, the counter SHALL increment; when it equals DB_CYCLES-1 while s2 still differs, level SHALL take s2 on that edge and the counter SHALL clear.
REQ-017 A clean btn step held steady SHALL therefore change level on the (DB_CYCLES+2)th rising edge after the first edge that samples the new value.
REQ-018 A btn excursion whose synchronised width is shorter than DB_CYCLES cycles SHALL NOT change level or produce any pulse.
REQ-019 rise and fall SHALL be registered and asserted in the same cycle level shows the new value, for exactly one cycle.
REQ-020 toggle SHALL invert on the edge where rise is generated.
REQ-021 If clr_toggle[i] is high on that edge, toggle[i] SHALL be 0 instead; clear wins over a simultaneous rise.
REQ-022 Each channel SHALL have a hold counter that is cleared while level is 0 and increments while level is 1.
REQ-023 The hold counter SHALL saturate at LONG_CYCLES and never wrap.
REQ-024 long_press[i] SHALL pulse for one cycle when the hold counter reaches LONG_CYCLES; it SHALL fire at most once per press.
REQ-025 long_press SHALL appear on the edge where level has been 1 for LONG_CYCLES cycles, i.e. LONG_CYCLES cycles after rise.
REQ-026 A fall before the hold counter saturates SHALL suppress long_press for that press.
REQ-027 Channels SHALL be fully independent, and simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-028 any_rise SHALL be registered, coincident with rise.
REQ-029 Counter widths SHALL be clog2(DB_CYCLES+1) and clog2(LONG_CYCLES+1), minimum 1 bit.

Reset
REQ-030 While rst is high, s1, s2, level, rise, fall, toggle, long_press, any_rise and all counters SHALL be 0, asynchronously.
REQ-031 A reset asserted mid-debounce or mid-hold SHALL discard the partial count; after release, a btn already high SHALL be re-qualified from the start and produce a fresh rise.
REQ-032 Release of rst SHALL be synchronous to clk from the integrator's side; the block adds no reset synchroniser.

Verification (N=5, DB_CYCLES=4, LONG_CYCLES=16)
REQ-033 Step: btn[0] 0->1 held -> level[0]=1 and rise[0]=1 for one cycle, 6 edges after first sample; toggle[0]=1; any_rise=1 same cycle.
REQ-034 Glitch: btn[1] high for 3 synchronised cycles then low -> no level, rise or fall change on any channel.
REQ-035 Long press: btn[2] held 40 cycles -> one long_press[2] pulse exactly 16 cycles after rise[2], none afterwards; release -> fall[2] after 6 edges.
REQ-036 Short press: btn[2] held 10 cycles -> rise and fall, no long_press.
REQ-037 Toggle clear: clr_toggle[3]=1 in the same cycle rise[3] occurs -> toggle[3]=0; next press -> toggle[3]=1.
REQ-038 Reset mid-count: btn[4] held high, rst pulsed during hold count 8 -> all outputs 0 immediately; after release, rise[4] repeats 6 edges later and long_press[4] fires 16 cycles after that.
